raw_window_7x7_feeder: RTL and testbench
========================================

// Module: raw_window_7x7_feeder
// PURPOSE
//  Upstream stage of the 7x7 Hamilton demosaic core. Takes a raster RAW10 Bayer stream, buffers 6 lines,
//  presents one 7-pixel column per cycle on D0..D6 (D0 = oldest row, D6 = newest), plus Bayer phase X/Y
//  and OUT_VALID, all aligned to the demosaic core's centre pixel (window row 4, column 4).
//  The core shifts its window every CLK, so this block guarantees column-contiguous output within a line.
// PARAMETERS
//  IMG_WIDTH    1280   active pixels per line (>= 8)
//  IMG_HEIGHT   720    active lines per frame (>= 8)
//  BAYER_PHASE  2'b00  {Y,X} code of pixel (row0,col0); 00=R, 01/10=G, 11=B (core decode)
// PORTS
//  CLK        in   1   clock
//  RST        in   1   synchronous reset, active-high
//  IN_VALID   in   1   IN_DATA valid this cycle
//  IN_SOF     in   1   first pixel of frame; only sampled when IN_VALID=1
//  IN_DATA    in   10  RAW pixel, raster order
//  D0..D6     out  10  column of rows r-6..r (r = row of current input pixel)
//  X          out  1   column-phase bit of the core's centre pixel
//  Y          out  1   row-phase bit of the core's centre pixel
//  OUT_VALID  out  1   core's centre pixel has full 7x7 support inside the image
//  ERR        out  1   sticky protocol error; cleared only by RST
// BEHAVIOUR
//  Reset: D0..D6=0, X=Y=0, OUT_VALID=0, ERR=0, col=row=0, state IDLE. Line RAM contents are not reset.
//  Storage: 6 line RAMs, depth IMG_WIDTH, shared address = col. Per accepted pixel:
//   - LB0[col] <= IN_DATA.
//   - LB(k+1)[col] <= LBk[col].
//  Latency: exactly 1 CLK from accepted pixel (col c, row r) to D6 = that pixel,
//   D5 = row r-1 col c, ..., D0 = row r-6 col c.
//  Cycle with no accepted pixel: next D0..D6=0, OUT_VALID=0, X/Y hold.
//  Rows r-k<0 output stale RAM data (OUT_VALID masks them).
//  Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1.
//   - col wraps to 0 after IMG_WIDTH-1 and row then increments.
//   - After last pixel of row IMG_HEIGHT-1, return to IDLE.
//  FSM:
//   IDLE -> LINE         on IN_VALID & IN_SOF; pixel taken as (0,0).
//                        IN_VALID without SOF is dropped.
//   LINE -> GAP          after col IMG_WIDTH-1 pixel (not last row).
//   LINE -> IDLE         after last pixel of frame.
//   GAP  -> LINE         on next IN_VALID; IN_VALID low in GAP is legal (h-blank).
//   LINE, IN_VALID=0     mid-line (col!=0): ERR<=1, -> IDLE; rest of frame dropped until next SOF.
//   LINE/GAP, SOF+VALID  ERR<=1; restart frame at (0,0) with this pixel.
//  Centre alignment: the core's centre lags D by 3 columns, so the centre seen on cycle t+1
//   belongs to col c-3 of row r-3, where (c,r) is the pixel accepted on cycle t.
//  Registered with D (same cycle as D):
//   X         <= (c-3)[0] ^ BAYER_PHASE[0]
//   Y         <= (r-3)[0] ^ BAYER_PHASE[1]
//   OUT_VALID <= 1 iff 6<=c<=IMG_WIDTH-1 and 6<=r<=IMG_HEIGHT-1,
//                i.e. centre cols 3..W-4, rows 3..H-4.
//  The core adds its own 1-cycle register; realigning its RGB with OUT_VALID is the core wrapper's job.
//  Simultaneous RST with any input: RST wins; pixel dropped. RST mid-frame: IDLE, wait for SOF.
// TESTING
//  1. 16x12 frame, ramp IN_DATA=row*16+col, no gaps, 4-cycle h-blank:
//     at (c=8,r=7): D6=120, D0=24; OUT_VALID=1 for exactly 10x6=60 cycles.
//  2. BAYER_PHASE=00, accepted (c=6,r=6): next cycle X=1, Y=1 (centre (3,3) = B code 11);
//     (c=7,r=6) -> X=0, Y=1.
//  3. IN_VALID low at col 5 of row 2 -> ERR=1 next cycle, OUT_VALID stays 0,
//     no output until next SOF; ERR survives SOF.
//  4. IN_SOF at col 9 of row 8 -> ERR=1; that pixel output with row=col=0 context,
//     OUT_VALID low for next 6 rows.
//  5. RST asserted mid-line (row 7) -> next cycle all outputs 0, state IDLE;
//     pixels without SOF ignored; fresh frame then matches test 1.
//  6. Back-to-back frames, zero h-blank: second SOF right after last pixel accepted,
//     ERR=0, 60 OUT_VALID cycles per frame.

Source files
------------

// File: rtl/raw_window_7x7_feeder_if.sv
// Pixel stream in, 7-row column window out, for the 7x7 demosaic feeder.
// master = stream source / window consumer side, slave = the feeder itself.
interface raw_window_7x7_feeder_if;
   logic       in_valid;
   logic       in_sof;
   logic [9:0] in_data;
   logic [9:0] d0, d1, d2, d3, d4, d5, d6;
   logic       x;
   logic       y;
   logic       out_valid;
   logic       err;

   modport master (
      output in_valid, in_sof, in_data,
      input  d0, d1, d2, d3, d4, d5, d6, x, y, out_valid, err
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output d0, d1, d2, d3, d4, d5, d6, x, y, out_valid, err
   );
endinterface

// File: rtl/raw_window_7x7_feeder.sv
// Six-line buffer that turns a raster RAW10 stream into one 7-pixel column per cycle,
// with Bayer phase and full-support flag aligned to the demosaic core's centre pixel.
//
// state  | meaning
// S_IDLE | waiting for SOF; non-SOF pixels are dropped
// S_LINE | inside a line, a pixel is expected every cycle
// S_GAP  | between lines, horizontal blanking allowed
module raw_window_7x7_feeder #(
   parameter int         IMG_WIDTH   = 1280,
   parameter int         IMG_HEIGHT  = 720,
   parameter logic [1:0] BAYER_PHASE = 2'b00
) (
   input logic                    clk,
   input logic                    rst,
   raw_window_7x7_feeder_if.slave px
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [9:0]    d_q [7];
   logic [9:0]    d_d [7];
   logic          x_q, x_d;
   logic          y_q, y_d;
   logic          ov_q, ov_d;
   logic          err_q, err_d;

   logic          accept;
   logic [CW-1:0] acc_col;
   logic [RW-1:0] acc_row;

   // One word per column holds rows r-1 (bits 9:0) back to r-6 (bits 59:50).
   logic [59:0]   lb_mem [IMG_WIDTH];
   logic [59:0]   lb_rd;

   assign lb_rd = lb_mem[acc_col];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      err_d   = err_q;
      x_d     = x_q;
      y_d     = y_q;
      ov_d    = 1'b0;
      d_d     = '{default: '0};
      accept  = 1'b0;
      acc_col = '0;
      acc_row = '0;

      unique case (state_q)
         S_IDLE: begin
            if (px.in_valid && px.in_sof) accept = 1'b1;
         end
         S_LINE: begin
            if (!px.in_valid) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               col_d   = '0;
               row_d   = '0;
            end else begin
               accept = 1'b1;
               if (px.in_sof) begin
                  err_d = 1'b1;
               end else begin
                  acc_col = col_q;
                  acc_row = row_q;
               end
            end
         end
         S_GAP: begin
            if (px.in_valid) begin
               accept = 1'b1;
               if (px.in_sof) err_d = 1'b1;
               else           acc_row = row_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         if (acc_col == LAST_COL) begin
            col_d = '0;
            if (acc_row == LAST_ROW) begin
               row_d   = '0;
               state_d = S_IDLE;
            end else begin
               row_d   = acc_row + 1'b1;
               state_d = S_GAP;
            end
         end else begin
            col_d   = acc_col + 1'b1;
            row_d   = acc_row;
            state_d = S_LINE;
         end

         d_d[6] = px.in_data;
         for (int k = 0; k < 6; k++) d_d[k] = lb_rd[10*(5-k) +: 10];

         // Centre is 3 columns and 3 rows back; subtracting 3 just flips the LSB.
         x_d  = ~acc_col[0] ^ BAYER_PHASE[0];
         y_d  = ~acc_row[0] ^ BAYER_PHASE[1];
         ov_d = (acc_col >= CW'(6)) && (acc_row >= RW'(6));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         x_q     <= 1'b0;
         y_q     <= 1'b0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
         for (int k = 0; k < 7; k++) d_q[k] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
         for (int k = 0; k < 7; k++) d_q[k] <= d_d[k];
      end
   end

   // Line RAM is deliberately not reset; a pixel coinciding with reset is not stored.
   always_ff @(posedge clk) begin
      if (accept && !rst) lb_mem[acc_col] <= {lb_rd[49:0], px.in_data};
   end

   assign px.d0        = d_q[0];
   assign px.d1        = d_q[1];
   assign px.d2        = d_q[2];
   assign px.d3        = d_q[3];
   assign px.d4        = d_q[4];
   assign px.d5        = d_q[5];
   assign px.d6        = d_q[6];
   assign px.x         = x_q;
   assign px.y         = y_q;
   assign px.out_valid = ov_q;
   assign px.err       = err_q;
endmodule

// File: tb/tb_raw_window_7x7_feeder.sv
// Directed bench for raw_window_7x7_feeder on a 16x12 frame; per-column pixel
// history predicts every window column, expectations are queued then compared.
module tb_raw_window_7x7_feeder;
   localparam int         W  = 16;
   localparam int         H  = 12;
   localparam logic [1:0] BP = 2'b00;

   typedef struct {
      logic [69:0] d;
      logic [69:0] m;
      logic        x;
      logic        y;
      logic        ov;
      logic        err;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   raw_window_7x7_feeder_if px();

   raw_window_7x7_feeder #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .BAYER_PHASE(BP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .px (px)
   );

   exp_t       sb[$];
   logic [9:0] hist [W][$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         ov_seen = 0;
   logic       x_hold = 1'b0;
   logic       y_hold = 1'b0;
   logic       err_exp = 1'b0;
   logic [9:0] obs_d6, obs_d0;
   logic       obs_x, obs_y;

   task automatic compare_out();
      exp_t        e;
      logic [69:0] obs;
      obs = {px.d6, px.d5, px.d4, px.d3, px.d2, px.d1, px.d0};
      n_cmp++;
      assert (sb.size() > 0) else begin
         n_err++;
         $error("FAIL scoreboard_empty obs=%0d exp=nonzero", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         assert ((obs & e.m) === (e.d & e.m)) else begin
            n_err++;
            $error("FAIL %s_window obs=%h exp=%h mask=%h", e.tag, obs, e.d, e.m);
         end
         n_cmp++;
         assert ({px.x, px.y, px.out_valid, px.err} === {e.x, e.y, e.ov, e.err}) else begin
            n_err++;
            $error("FAIL %s_flags obs(x,y,ov,err)=%b exp=%b", e.tag,
                   {px.x, px.y, px.out_valid, px.err}, {e.x, e.y, e.ov, e.err});
         end
      end
      obs_d6 = px.d6;
      obs_d0 = px.d0;
      obs_x  = px.x;
      obs_y  = px.y;
      if (px.out_valid === 1'b1) ov_seen++;
   endtask

   task automatic step(input logic v, input logic s, input logic [9:0] dat,
                       input bit acc, input int c, input int r, input string tag);
      exp_t e;
      int   n;
      bit   cpar, rpar;
      px.in_valid = v;
      px.in_sof   = s;
      px.in_data  = dat;
      e.d   = '0;
      e.m   = '1;
      e.x   = x_hold;
      e.y   = y_hold;
      e.ov  = 1'b0;
      e.err = err_exp;
      e.tag = tag;
      if (acc) begin
         n = hist[c].size();
         e.d[60 +: 10] = dat;
         for (int j = 1; j <= 6; j++) begin
            if (n >= j) e.d[10*(6-j) +: 10] = hist[c][n-j];
            else        e.m[10*(6-j) +: 10] = '0;
         end
         hist[c].push_back(dat);
         cpar   = ((c - 3) & 1) != 0;
         rpar   = ((r - 3) & 1) != 0;
         e.x    = cpar ^ BP[0];
         e.y    = rpar ^ BP[1];
         e.ov   = (c >= 6) && (c <= W - 1) && (r >= 6) && (r <= H - 1);
         x_hold = e.x;
         y_hold = e.y;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic do_reset(input int cycles, input logic v, input logic s);
      exp_t e;
      rst     = 1'b1;
      x_hold  = 1'b0;
      y_hold  = 1'b0;
      err_exp = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         px.in_valid = v;
         px.in_sof   = s;
         px.in_data  = 10'h3a5;
         e.d = '0; e.m = '1; e.x = 1'b0; e.y = 1'b0; e.ov = 1'b0; e.err = 1'b0;
         e.tag = "reset";
         sb.push_back(e);
         @(posedge clk);
         #1;
         compare_out();
      end
      rst = 1'b0;
   endtask

   // Sends a frame from (0,0); stops before pixel (stop_r, stop_c) when that is inside the frame.
   task automatic send_frame(input int base, input int hblank, input int stop_r,
                             input int stop_c, input bit check_pts);
      ov_seen = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == stop_r && c == stop_c) return;
            step(1'b1, (r == 0 && c == 0), 10'(base + r*16 + c), 1'b1, c, r, "pix");
            if (check_pts && r == 7 && c == 8) begin
               n_cmp++;
               assert (obs_d6 === 10'(base + 120)) else begin
                  n_err++;
                  $error("FAIL d6_at_c8r7 obs=%0d exp=%0d", obs_d6, base + 120);
               end
               n_cmp++;
               assert (obs_d0 === 10'(base + 24)) else begin
                  n_err++;
                  $error("FAIL d0_at_c8r7 obs=%0d exp=%0d", obs_d0, base + 24);
               end
            end
            if (check_pts && r == 6 && (c == 6 || c == 7)) begin
               n_cmp++;
               assert ({obs_x, obs_y} === ((c == 6) ? 2'b11 : 2'b01)) else begin
                  n_err++;
                  $error("FAIL phase_c%0dr6 obs(x,y)=%b exp=%b", c, {obs_x, obs_y},
                         (c == 6) ? 2'b11 : 2'b01);
               end
            end
         end
         if (r != H - 1)
            for (int b = 0; b < hblank; b++) step(1'b0, 1'b0, 10'd0, 1'b0, 0, 0, "hblank");
      end
      n_cmp++;
      assert (ov_seen == 60) else begin
         n_err++;
         $error("FAIL ov_count obs=%0d exp=60", ov_seen);
      end
   endtask

   initial begin
      rst         = 1'b1;
      px.in_valid = 1'b0;
      px.in_sof   = 1'b0;
      px.in_data  = '0;

      do_reset(2, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'(i + 7), 1'b0, 0, 0, "idle_drop");

      // Ramp frame with 4-cycle h-blank, centre phase and window spot checks.
      send_frame(0, 4, -1, -1, 1'b1);

      // Stall mid-line: error, then drop everything until SOF; ERR stays sticky.
      send_frame(50, 4, 2, 5, 1'b0);
      err_exp = 1'b1;
      step(1'b0, 1'b0, 10'd0, 1'b0, 0, 0, "stall");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 10'(i), 1'b0, 0, 0, "post_err_drop");
      send_frame(300, 4, 1, 0, 1'b0);
      do_reset(1, 1'b0, 1'b0);

      // Early SOF at col 9 of row 8: restart with that pixel at (0,0).
      send_frame(0, 4, 8, 9, 1'b0);
      err_exp = 1'b1;
      send_frame(400, 4, -1, -1, 1'b0);

      // Reset mid-line of row 7 with a SOF pixel present: reset wins.
      send_frame(100, 4, 7, 5, 1'b0);
      do_reset(1, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 10'(i + 900), 1'b0, 0, 0, "post_rst_drop");
      send_frame(0, 4, -1, -1, 1'b1);

      // Back-to-back frames, no blanking anywhere.
      send_frame(200, 0, -1, -1, 1'b1);
      send_frame(600, 0, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
